// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and constants for the instruction/data memory arbiter.
//   - arb_state_e : arbiter FSM states (IDLE, I_FILL, D_ACC)
//   - LINE_WORDS  : default icache line size in 32-bit words
//   - BEAT_W      : beat index width for the default line size
//   - grant_lat_t : address/data/we captured when a request is granted
package mem_arb_pkg;

    localparam int LINE_WORDS = 4;

    // Width of a word index within a line of n words (n is a power of 2, n >= 2).
    function automatic int beat_w(input int n);
        return $clog2(n);
    endfunction

    localparam int BEAT_W = beat_w(LINE_WORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_FILL = 2'd1,
        D_ACC  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
    } grant_lat_t;

endpackage

// File: rtl/refill_beat_counter.sv
// refill_beat_counter
//   Word index within the icache line currently being refilled.
//   Ports:
//     clk, rst_b : clock, asynchronous active-low reset
//     clr        : force beat to 0 (held while the arbiter is idle)
//     inc        : advance beat by one (a refill word was accepted)
//     beat       : current word index
//     last       : beat is the final word of the line
module refill_beat_counter #(
    parameter int LINE_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          rst_b,
    input  logic                          clr,
    input  logic                          inc,
    output logic [$clog2(LINE_WORDS)-1:0] beat,
    output logic                          last
);

    localparam int BW = $clog2(LINE_WORDS);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            beat <= '0;
        end else if (clr) begin
            beat <= '0;
        end else if (inc) begin
            // Wrap on the last word coincides with the fill completing.
            beat <= beat + BW'(1);
        end
    end

    assign last = (beat == BW'(LINE_WORDS - 1));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one main-memory port between icache line refills and
//   single-word dcache accesses. Data side wins ties; a grant runs to
//   completion and is always followed by one idle cycle.
//   Ports:
//     clk, rst_b                 : clock, asynchronous active-low reset
//     i_req, i_addr              : icache miss request and miss address
//     d_req, d_we, d_addr,
//     d_wdata                    : dcache request, store flag, address, store data
//     mem_req, mem_we, mem_addr,
//     mem_wdata                  : main-memory request
//     mem_ready, mem_rdata       : main-memory beat completion and read data
//     i_fill_valid, i_fill_idx,
//     i_fill_word                : refill word stream into the icache
//     i_done, d_done             : one-cycle completion pulses
//     d_rdata                    : load data, valid with d_done
//     freeze                     : pipeline stall while any request is unserved
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LINE_WORDS = mem_arb_pkg::LINE_WORDS
) (
    input  logic                          clk,
    input  logic                          rst_b,
    input  logic                          i_req,
    input  logic [31:0]                   i_addr,
    input  logic                          d_req,
    input  logic                          d_we,
    input  logic [31:0]                   d_addr,
    input  logic [31:0]                   d_wdata,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [31:0]                   mem_addr,
    output logic [31:0]                   mem_wdata,
    input  logic                          mem_ready,
    input  logic [31:0]                   mem_rdata,
    output logic                          i_fill_valid,
    output logic [$clog2(LINE_WORDS)-1:0] i_fill_idx,
    output logic [31:0]                   i_fill_word,
    output logic                          i_done,
    output logic                          d_done,
    output logic [31:0]                   d_rdata,
    output logic                          freeze
);

    localparam int IDX_W = beat_w(LINE_WORDS);

    arb_state_e          state, state_nxt;
    grant_lat_t          lat;
    logic [IDX_W-1:0]    beat;
    logic                beat_last;
    logic                beat_inc;
    logic                beat_clr;

    // ---------------------------------------------------------------
    // Beat counter: parked at 0 while idle so every grant starts at word 0.
    // ---------------------------------------------------------------
    assign beat_clr = (state == IDLE);
    assign beat_inc = (state == I_FILL) && mem_ready;

    refill_beat_counter #(
        .LINE_WORDS (LINE_WORDS)
    ) u_beat (
        .clk   (clk),
        .rst_b (rst_b),
        .clr   (beat_clr),
        .inc   (beat_inc),
        .beat  (beat),
        .last  (beat_last)
    );

    // ---------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------
    // FSM next state
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (d_req) begin
                    state_nxt = D_ACC;
                end else if (i_req) begin
                    state_nxt = I_FILL;
                end
            end
            I_FILL: begin
                if (mem_ready && beat_last) begin
                    state_nxt = IDLE;
                end
            end
            D_ACC: begin
                if (mem_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Grant latch: captured only on the IDLE -> busy transition, so the
    // request side may change freely once the grant is taken.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            lat <= '0;
        end else if (state == IDLE) begin
            if (d_req) begin
                lat <= '{addr: d_addr, wdata: d_wdata, we: d_we};
            end else if (i_req) begin
                lat <= '{addr: i_addr, wdata: 32'h0, we: 1'b0};
            end
        end
    end

    // ---------------------------------------------------------------
    // FSM outputs
    // ---------------------------------------------------------------
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = lat.addr;
        i_fill_valid = 1'b0;
        i_done       = 1'b0;
        d_done       = 1'b0;
        unique case (state)
            I_FILL: begin
                mem_req      = 1'b1;
                // Walk the line from word 0 regardless of the missing word.
                mem_addr     = {lat.addr[31:IDX_W+2], beat, 2'b00};
                i_fill_valid = mem_ready;
                i_done       = mem_ready && beat_last;
            end
            D_ACC: begin
                mem_req  = 1'b1;
                mem_we   = lat.we;
                d_done   = mem_ready;
            end
            default: ;
        endcase
    end

    assign mem_wdata   = lat.wdata;
    assign i_fill_idx  = beat;
    assign i_fill_word = mem_rdata;
    assign d_rdata     = mem_rdata;

    assign freeze = (i_req & ~i_done) | (d_req & ~d_done);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        i_fill_valid;
    logic [1:0]  i_fill_idx;
    logic [31:0] i_fill_word;
    logic        i_done;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        freeze;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.LINE_WORDS(4)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .d_req        (d_req),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .i_fill_valid (i_fill_valid),
        .i_fill_idx   (i_fill_idx),
        .i_fill_word  (i_fill_word),
        .i_done       (i_done),
        .d_done       (d_done),
        .d_rdata      (d_rdata),
        .freeze       (freeze)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Called in the first I_FILL cycle; mem_ready is high every cycle.
    // Returns in the IDLE cycle that follows i_done.
    task automatic run_fill(input string tag, input logic [31:0] base, input logic last_freeze);
        for (int k = 0; k < 4; k++) begin
            mem_ready = 1'b1;
            mem_rdata = 32'hF000_0000 | base | 32'(k);
            #1;
            chk({tag, "_req"},   32'(mem_req), 32'd1);
            chk({tag, "_we"},    32'(mem_we), 32'd0);
            chk({tag, "_addr"},  mem_addr, base + 32'(4 * k));
            chk({tag, "_valid"}, 32'(i_fill_valid), 32'd1);
            chk({tag, "_idx"},   32'(i_fill_idx), 32'(k));
            chk({tag, "_word"},  i_fill_word, 32'hF000_0000 | base | 32'(k));
            chk({tag, "_idone"}, 32'(i_done), (k == 3) ? 32'd1 : 32'd0);
            chk({tag, "_frz"},   32'(freeze), (k == 3) ? 32'(last_freeze) : 32'd1);
            tick();
        end
    endtask

    logic       rdy_seq [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0] idx_seq [6] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3};

    initial begin
        rst_b = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
        #3;
        // ---- reset state, before any clock edge ----
        chk("rst_req",   32'(mem_req), 32'd0);
        chk("rst_we",    32'(mem_we), 32'd0);
        chk("rst_valid", 32'(i_fill_valid), 32'd0);
        chk("rst_idone", 32'(i_done), 32'd0);
        chk("rst_ddone", 32'(d_done), 32'd0);
        chk("rst_wdata", mem_wdata, 32'h0);
        tick(); tick();
        rst_b = 1'b1;
        tick();

        // ---- single load, mem_ready tied high ----
        mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        #1;
        chk("ld_idle_req",   32'(mem_req), 32'd0);
        chk("ld_idle_ddone", 32'(d_done), 32'd0);
        chk("ld_idle_frz",   32'(freeze), 32'd1);
        tick();
        #1;
        chk("ld_req",   32'(mem_req), 32'd1);
        chk("ld_we",    32'(mem_we), 32'd0);
        chk("ld_addr",  mem_addr, 32'h100);
        chk("ld_ddone", 32'(d_done), 32'd1);
        chk("ld_rdata", d_rdata, 32'h1111_2222);
        chk("ld_frz",   32'(freeze), 32'd0);
        chk("ld_valid", 32'(i_fill_valid), 32'd0);
        tick();
        d_req = 1'b0;
        #1;
        chk("ld_post_req",   32'(mem_req), 32'd0);
        chk("ld_post_ddone", 32'(d_done), 32'd0);
        chk("ld_post_frz",   32'(freeze), 32'd0);

        // ---- full line fill from a mid-line miss address ----
        i_req = 1'b1; i_addr = 32'h208;
        tick();
        run_fill("fill", 32'h200, 1'b0);
        i_req = 1'b0;
        #1;
        chk("fill_post_req", 32'(mem_req), 32'd0);
        tick();

        // ---- simultaneous I and D requests: D first, one idle, then fill ----
        i_req = 1'b1; i_addr = 32'h404;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        mem_rdata = 32'h3333_0000;
        #1;
        chk("both_idle_frz", 32'(freeze), 32'd1);
        tick();
        #1;
        chk("both_d_addr",  mem_addr, 32'h300);
        chk("both_d_ddone", 32'(d_done), 32'd1);
        chk("both_d_rdata", d_rdata, 32'h3333_0000);
        chk("both_d_frz",   32'(freeze), 32'd1);
        tick();
        d_req = 1'b0;
        #1;
        chk("both_gap_req", 32'(mem_req), 32'd0);
        chk("both_gap_frz", 32'(freeze), 32'd1);
        tick();
        run_fill("both_i", 32'h400, 1'b0);
        i_req = 1'b0;
        tick();

        // ---- mem_ready ignored in IDLE, then stalls 1-0-0-1 during fill ----
        i_req = 1'b1; i_addr = 32'h500;
        mem_ready = 1'b1;
        #1;
        chk("idle_rdy_valid", 32'(i_fill_valid), 32'd0);
        chk("idle_rdy_idone", 32'(i_done), 32'd0);
        chk("idle_rdy_ddone", 32'(d_done), 32'd0);
        tick();
        for (int c = 0; c < 6; c++) begin
            mem_ready = rdy_seq[c];
            mem_rdata = 32'hB000_0000 + 32'(c);
            #1;
            chk("stall_addr",  mem_addr, 32'h500 + 32'(4 * idx_seq[c]));
            chk("stall_valid", 32'(i_fill_valid), 32'(rdy_seq[c]));
            chk("stall_idx",   32'(i_fill_idx), 32'(idx_seq[c]));
            chk("stall_idone", 32'(i_done), (c == 5) ? 32'd1 : 32'd0);
            tick();
        end
        i_req = 1'b0;
        #1;
        chk("stall_post_req", 32'(mem_req), 32'd0);
        tick();

        // ---- reset mid-burst after two beats ----
        i_req = 1'b1; i_addr = 32'h600; mem_ready = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("rb_beat_idx", 32'(i_fill_idx), 32'(k));
            tick();
        end
        #1;
        chk("rb_pre_req", 32'(mem_req), 32'd1);
        rst_b = 1'b0;
        #1;
        chk("rb_req",   32'(mem_req), 32'd0);
        chk("rb_valid", 32'(i_fill_valid), 32'd0);
        chk("rb_idone", 32'(i_done), 32'd0);
        tick();
        chk("rb_hold_idone", 32'(i_done), 32'd0);
        rst_b = 1'b1;
        #1;
        chk("rb_rel_req", 32'(mem_req), 32'd0);
        tick();
        run_fill("rb_fill", 32'h600, 1'b0);
        i_req = 1'b0;
        tick();

        // ---- store raised during a fill waits for the fill to finish ----
        i_req = 1'b1; i_addr = 32'h70C;
        tick();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
        run_fill("st_fill", 32'h700, 1'b1);
        i_req = 1'b0;
        #1;
        chk("st_gap_req", 32'(mem_req), 32'd0);
        chk("st_gap_frz", 32'(freeze), 32'd1);
        tick();
        #1;
        chk("st_req",   32'(mem_req), 32'd1);
        chk("st_we",    32'(mem_we), 32'd1);
        chk("st_addr",  mem_addr, 32'h40);
        chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("st_ddone", 32'(d_done), 32'd1);
        chk("st_frz",   32'(freeze), 32'd0);
        tick();
        d_req = 1'b0; d_we = 1'b0;
        #1;
        chk("st_post_req", 32'(mem_req), 32'd0);
        chk("st_post_we",  32'(mem_we), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
